// File: rtl/arb8_rr_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
// No logic of its own; constants, state encoding and a one-hot helper.
// Optional forced release is controlled in arb8_rr by the ARB8_TIMEOUT_EN macro.
package arb8_rr_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot expansion of an owner index (the DMUX8WAY function with in=1).
    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] s);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb8_rr_pick8.sv
// Rotate-priority picker: first set request at or after i_ptr, wrapping 7 -> 0.
// Latency: purely combinational.
// Backpressure: none; o_any low means o_idx is don't-care (returns i_ptr).
module rr_pick8
    import arb8_rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        o_any  = |i_req;
        o_idx  = i_ptr;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/arb8_rr.sv
// Round-robin arbiter for 8 requesters; holds grant until done, abandon or (ARB8_TIMEOUT_EN) timeout.
// Latency: grant registered one edge after req; back-to-back regrant on the release edge.
// Backpressure: owner is held until release; other requesters wait, no combinational req->out path.
module arb8_rr
    import arb8_rr_pkg::*;
#(
    parameter int MAX_HOLD = 16
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_done,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_busy,
    output logic               o_timeout
);

    state_t             r_state;
    state_t             w_nxt_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_nxt_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_nxt_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   w_pick_ptr;
    logic [SEL_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_force;
    logic               w_release;
    logic               w_load;

    // While granted the search must start just past the owner, so the picker
    // already sees the post-release pointer and a regrant needs no idle cycle.
    assign w_pick_ptr = (r_state == ST_GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

    rr_pick8 u_pick (
        .i_req (i_req),
        .i_ptr (w_pick_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

`ifdef ARB8_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign w_force = (r_state == ST_GRANT) && (r_cnt == CNT_W'(MAX_HOLD - 1));

    // Hold counter restarts on every new grant; timeout pulses only when done did not win.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force && !i_done;
            if (w_load || (w_nxt_state == ST_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MAX_HOLD < 2);
    assign w_force      = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // Any of done, owner abandoning, or forced release frees the resource.
    assign w_release = i_done || !i_req[r_sel] || w_force;

    // Next-state, owner and pointer selection.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_sel   = w_pick_idx;
                    w_load      = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_nxt_ptr = r_sel + SEL_W'(1);
                    if (w_pick_any) begin
                        w_nxt_sel = w_pick_idx;
                        w_load    = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State, owner, pointer and decoded grant registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_grant <= (w_nxt_state == ST_GRANT) ? onehot8(w_nxt_sel) : '0;
        end
    end

    assign o_grant = r_grant;
    assign o_sel   = r_sel;
    assign o_busy  = (r_state == ST_GRANT);

endmodule
